// File: rtl/pea_pool_if.sv
// Bus bundle between pea_pool and the logic around it.
// The master side is the game logic: it spawns peas, reports kills, ticks frames and scans pixels.
// The slave side is the pea pool itself.
interface pea_pool_if #(
    parameter int NUM_PEAS = 20,
    parameter int IDX_W    = 5
);
    // Frame and spawn control
    logic                frame_tick;
    logic                spawn_valid;
    logic                spawn_ready;
    logic [9:0]          spawn_x;
    logic [9:0]          spawn_y;
    logic                spawn_type;

    // Collision reports
    logic                kill_valid;
    logic [IDX_W-1:0]    kill_idx;

    // Pixel scan and draw outputs
    logic [9:0]          DrawX;
    logic [9:0]          DrawY;
    logic                pea_on;
    logic [23:0]         RGB_pea;
    logic [IDX_W-1:0]    pea_idx;

    // Pool status
    logic [NUM_PEAS-1:0] active_mask;
    logic [5:0]          active_count;

    modport master (
        output frame_tick, spawn_valid, spawn_x, spawn_y, spawn_type,
        output kill_valid, kill_idx, DrawX, DrawY,
        input  spawn_ready, pea_on, RGB_pea, pea_idx, active_mask, active_count
    );

    modport slave (
        input  frame_tick, spawn_valid, spawn_x, spawn_y, spawn_type,
        input  kill_valid, kill_idx, DrawX, DrawY,
        output spawn_ready, pea_on, RGB_pea, pea_idx, active_mask, active_count
    );
endinterface

// File: rtl/pea_pool.sv
// Projectile pool: owns NUM_PEAS pea slots, allocates them on spawn,
// moves them right on each frame tick, retires them off-lawn or on kill,
// and produces a registered per-pixel pea colour for the colour mapper.
module pea_pool #(
    parameter int          NUM_PEAS     = 20,
    parameter int          IDX_W        = 5,
    parameter int          PEA_SIZE     = 8,
    parameter int          STEP         = 4,
    parameter int          X_LIMIT      = 639,
    parameter logic [23:0] COLOR_NORMAL = 24'hF0BC3C,
    parameter logic [23:0] COLOR_FROZEN = 24'h3CBCF0,
    parameter logic [23:0] COLOR_BG     = 24'h800080
) (
    input  logic        MAX10_CLK1_50,
    input  logic        Reset,
    pea_pool_if.slave   bus
);

    // Geometry constants widened to 11 bits so x + size / x + step never wrap.
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] SIZE_W  = 11'(PEA_SIZE);
    localparam logic [10:0] LIMIT_W = 11'(X_LIMIT);

    function automatic logic [23:0] pea_color(input logic frozen);
        return frozen ? COLOR_FROZEN : COLOR_NORMAL;
    endfunction

    function automatic logic [5:0] popcount(input logic [NUM_PEAS-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < NUM_PEAS; i++) begin
            n = n + {5'b0, v[i]};
        end
        return n;
    endfunction

    // Slot state
    logic [NUM_PEAS-1:0] act_q;
    logic [NUM_PEAS-1:0] type_q;
    logic [9:0]          x_q [NUM_PEAS];
    logic [9:0]          y_q [NUM_PEAS];

    // Next slot state
    logic [NUM_PEAS-1:0] act_d;
    logic [NUM_PEAS-1:0] type_d;
    logic [9:0]          x_d [NUM_PEAS];
    logic [9:0]          y_d [NUM_PEAS];

    logic [NUM_PEAS-1:0] free_oh;
    logic [NUM_PEAS-1:0] kill_oh;
    logic                spawn_fire;
    logic [5:0]          count_p1;

    // Pixel path
    logic [NUM_PEAS-1:0] hit;
    logic                pix_on;
    logic [IDX_W-1:0]    pix_idx;
    logic [23:0]         pix_rgb;
    logic                pea_on_p1;
    logic [IDX_W-1:0]    pea_idx_p1;
    logic [23:0]         rgb_p1;

    assign bus.spawn_ready = ~&act_q;
    assign spawn_fire      = bus.spawn_valid && bus.spawn_ready;

    // Pick the lowest inactive slot as the spawn target (one-hot).
    always_comb begin : free_pick
        logic found;
        found   = 1'b0;
        free_oh = '0;
        for (int i = 0; i < NUM_PEAS; i++) begin
            if (!act_q[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Decode the kill request; out-of-range or inactive targets select nothing.
    always_comb begin
        kill_oh = '0;
        for (int i = 0; i < NUM_PEAS; i++) begin
            kill_oh[i] = bus.kill_valid && (bus.kill_idx == IDX_W'(i)) && act_q[i];
        end
    end

    // Per-slot next state: spawn loads an idle slot, kill beats move, move may retire.
    always_comb begin : slot_next
        logic [10:0] nx;
        nx     = '0;
        act_d  = act_q;
        type_d = type_q;
        for (int i = 0; i < NUM_PEAS; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            nx     = {1'b0, x_q[i]} + STEP_W;
            if (spawn_fire && free_oh[i]) begin
                act_d[i]  = 1'b1;
                x_d[i]    = bus.spawn_x;
                y_d[i]    = bus.spawn_y;
                type_d[i] = bus.spawn_type;
            end else if (kill_oh[i]) begin
                act_d[i] = 1'b0;
            end else if (act_q[i] && bus.frame_tick) begin
                if (nx > LIMIT_W) begin
                    act_d[i] = 1'b0;
                end else begin
                    x_d[i] = nx[9:0];
                end
            end
        end
    end

    // Slot state and population count registers.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (Reset) begin
            act_q    <= '0;
            type_q   <= '0;
            count_p1 <= '0;
            for (int i = 0; i < NUM_PEAS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            act_q    <= act_d;
            type_q   <= type_d;
            count_p1 <= popcount(act_d);
            for (int i = 0; i < NUM_PEAS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    // Pixel coverage test against pre-update slot state; lowest covering slot wins.
    always_comb begin : pixel_pick
        logic        found;
        logic [10:0] dx;
        logic [10:0] dy;
        dx      = {1'b0, bus.DrawX};
        dy      = {1'b0, bus.DrawY};
        found   = 1'b0;
        hit     = '0;
        pix_idx = '0;
        pix_rgb = COLOR_BG;
        for (int i = 0; i < NUM_PEAS; i++) begin
            hit[i] = act_q[i]
                  && ({1'b0, x_q[i]} <= dx) && (dx < {1'b0, x_q[i]} + SIZE_W)
                  && ({1'b0, y_q[i]} <= dy) && (dy < {1'b0, y_q[i]} + SIZE_W);
            if (hit[i] && !found) begin
                found   = 1'b1;
                pix_idx = IDX_W'(i);
                pix_rgb = pea_color(type_q[i]);
            end
        end
        pix_on = |hit;
    end

    // ---- pixel stage p1: registered draw outputs ----
    always_ff @(posedge MAX10_CLK1_50) begin
        if (Reset) begin
            pea_on_p1  <= 1'b0;
            pea_idx_p1 <= '0;
            rgb_p1     <= COLOR_BG;
        end else begin
            pea_on_p1  <= pix_on;
            pea_idx_p1 <= pix_idx;
            rgb_p1     <= pix_rgb;
        end
    end

    assign bus.pea_on       = pea_on_p1;
    assign bus.pea_idx      = pea_idx_p1;
    assign bus.RGB_pea      = rgb_p1;
    assign bus.active_mask  = act_q;
    assign bus.active_count = count_p1;

endmodule

// File: tb/tb_pea_pool.sv
// Self-checking bench for pea_pool with a slot-list reference model.
module tb_pea_pool;
    localparam int NP = 20;
    localparam int IW = 5;
    localparam int PS = 8;
    localparam int STEP = 4;
    localparam int XL = 639;
    localparam logic [23:0] CN = 24'hF0BC3C;
    localparam logic [23:0] CF = 24'h3CBCF0;
    localparam logic [23:0] CB = 24'h800080;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pea_pool_if #(.NUM_PEAS(NP), .IDX_W(IW)) bus();

    pea_pool #(
        .NUM_PEAS(NP), .IDX_W(IW), .PEA_SIZE(PS), .STEP(STEP), .X_LIMIT(XL),
        .COLOR_NORMAL(CN), .COLOR_FROZEN(CF), .COLOR_BG(CB)
    ) dut (
        .MAX10_CLK1_50(clk),
        .Reset(rst),
        .bus(bus)
    );

    // Reference model: list of slots with plain integer coordinates.
    bit          m_act [NP];
    int          m_x   [NP];
    int          m_y   [NP];
    bit          m_t   [NP];
    bit          e_on;
    int          e_idx;
    logic [23:0] e_rgb;

    int errors = 0;
    int checks = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NP; i++) n += int'(m_act[i]);
        return n;
    endfunction

    function automatic logic [NP-1:0] m_mask();
        logic [NP-1:0] m = '0;
        for (int i = 0; i < NP; i++) m[i] = m_act[i];
        return m;
    endfunction

    task automatic idle();
        bus.frame_tick  = 1'b0;
        bus.spawn_valid = 1'b0;
        bus.spawn_x     = '0;
        bus.spawn_y     = '0;
        bus.spawn_type  = 1'b0;
        bus.kill_valid  = 1'b0;
        bus.kill_idx    = '0;
    endtask

    task automatic spawn(input int x, input int y, input bit t);
        bus.spawn_valid = 1'b1;
        bus.spawn_x     = 10'(x);
        bus.spawn_y     = 10'(y);
        bus.spawn_type  = t;
    endtask

    task automatic draw(input int x, input int y);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
    endtask

    // One clock: predict the pixel from pre-edge slots, apply the event rules, then advance.
    task automatic tick();
        int sp;
        int k;
        int dx;
        int dy;
        dx = int'(bus.DrawX);
        dy = int'(bus.DrawY);
        e_on = 1'b0; e_idx = 0; e_rgb = CB;
        for (int i = NP - 1; i >= 0; i--) begin
            if (m_act[i] && dx >= m_x[i] && dx < m_x[i] + PS && dy >= m_y[i] && dy < m_y[i] + PS) begin
                e_on = 1'b1; e_idx = i; e_rgb = m_t[i] ? CF : CN;
            end
        end
        if (rst) begin
            e_on = 1'b0; e_idx = 0; e_rgb = CB;
            for (int i = 0; i < NP; i++) begin
                m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_t[i] = 1'b0;
            end
        end else begin
            sp = -1;
            if (bus.spawn_valid) begin
                for (int i = 0; i < NP; i++) begin
                    if (!m_act[i] && sp < 0) sp = i;
                end
            end
            k = -1;
            if (bus.kill_valid && int'(bus.kill_idx) < NP) begin
                if (m_act[int'(bus.kill_idx)]) k = int'(bus.kill_idx);
            end
            for (int i = 0; i < NP; i++) begin
                if (i == sp) begin
                    m_act[i] = 1'b1; m_x[i] = int'(bus.spawn_x); m_y[i] = int'(bus.spawn_y); m_t[i] = bus.spawn_type;
                end else if (m_act[i] && i == k) begin
                    m_act[i] = 1'b0;
                end else if (m_act[i] && bus.frame_tick) begin
                    if (m_x[i] + STEP > XL) m_act[i] = 1'b0;
                    else m_x[i] = m_x[i] + STEP;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); draw(100, 100);
        rst = 1'b1; tick(); tick();
        rst = 1'b0; tick();
        checks++; if (bus.pea_on !== 1'b0) begin errors++; $display("FAIL reset_pea_on: got %0b want 0", bus.pea_on); end
        checks++; if (bus.RGB_pea !== CB) begin errors++; $display("FAIL reset_rgb: got %h want %h", bus.RGB_pea, CB); end
        checks++; if (bus.pea_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.pea_idx); end
        checks++; if (bus.active_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.active_count); end
        checks++; if (bus.active_mask !== '0) begin errors++; $display("FAIL reset_mask: got %h want 0", bus.active_mask); end
        checks++; if (bus.spawn_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus.spawn_ready); end
    endtask

    task automatic test_spawn_pixel();
        spawn(100, 200, 1'b0); tick(); idle();
        draw(103, 205); tick();
        checks++; if (bus.pea_on !== 1'b1 || bus.RGB_pea !== CN || bus.pea_idx !== 5'd0)
            begin errors++; $display("FAIL spawn_pixel: got on=%0b rgb=%h idx=%0d want on=1 rgb=%h idx=0", bus.pea_on, bus.RGB_pea, bus.pea_idx, CN); end
        draw(108, 205); tick();
        checks++; if (bus.pea_on !== 1'b0 || bus.RGB_pea !== CB)
            begin errors++; $display("FAIL spawn_right_edge: got on=%0b rgb=%h want on=0 rgb=%h", bus.pea_on, bus.RGB_pea, CB); end
    endtask

    task automatic test_move();
        bus.frame_tick = 1'b1; tick(); tick(); tick(); bus.frame_tick = 1'b0;
        draw(112, 200); tick();
        checks++; if (bus.pea_on !== 1'b1 || bus.pea_idx !== 5'd0)
            begin errors++; $display("FAIL move_x112: got on=%0b idx=%0d want on=1 idx=0", bus.pea_on, bus.pea_idx); end
        draw(111, 200); tick();
        checks++; if (bus.pea_on !== 1'b0) begin errors++; $display("FAIL move_x111: got on=%0b want 0", bus.pea_on); end
        spawn(636, 10, 1'b1); tick(); idle();
        checks++; if (bus.active_count !== 6'd2) begin errors++; $display("FAIL retire_before: got %0d want 2", bus.active_count); end
        draw(637, 12); tick();
        checks++; if (bus.pea_on !== 1'b1 || bus.RGB_pea !== CF || bus.pea_idx !== 5'd1)
            begin errors++; $display("FAIL frozen_pixel: got on=%0b rgb=%h idx=%0d want on=1 rgb=%h idx=1", bus.pea_on, bus.RGB_pea, bus.pea_idx, CF); end
        bus.frame_tick = 1'b1; tick(); idle();
        checks++; if (bus.active_count !== 6'd1 || bus.active_mask !== 20'h00001)
            begin errors++; $display("FAIL retire_after: got count=%0d mask=%h want count=1 mask=00001", bus.active_count, bus.active_mask); end
    endtask

    task automatic test_fill();
        logic [NP-1:0] want;
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            spawn(20 * (c % 20), 300, 1'(c % 2)); tick();
            want = (c >= 19) ? '1 : NP'((1 << (c + 1)) - 1);
            checks++; if (bus.active_mask !== want || bus.spawn_ready !== (c < 19))
                begin errors++; $display("FAIL fill_%0d: got mask=%h ready=%0b want mask=%h ready=%0b", c, bus.active_mask, bus.spawn_ready, want, c < 19); end
        end
        idle();
        checks++; if (bus.active_count !== 6'd20) begin errors++; $display("FAIL fill_count: got %0d want 20", bus.active_count); end
        bus.kill_valid = 1'b1; bus.kill_idx = 5'd7; tick(); idle();
        checks++; if (bus.active_mask !== 20'hFFF7F || bus.active_count !== 6'd19 || bus.spawn_ready !== 1'b1)
            begin errors++; $display("FAIL kill7: got mask=%h count=%0d ready=%0b want mask=fff7f count=19 ready=1", bus.active_mask, bus.active_count, bus.spawn_ready); end
        spawn(500, 50, 1'b1); tick(); idle();
        checks++; if (bus.active_mask !== 20'hFFFFF || bus.active_count !== 6'd20)
            begin errors++; $display("FAIL refill7: got mask=%h count=%0d want mask=fffff count=20", bus.active_mask, bus.active_count); end
        draw(502, 52); tick();
        checks++; if (bus.pea_on !== 1'b1 || bus.pea_idx !== 5'd7 || bus.RGB_pea !== CF)
            begin errors++; $display("FAIL refill7_pixel: got on=%0b idx=%0d rgb=%h want on=1 idx=7 rgb=%h", bus.pea_on, bus.pea_idx, bus.RGB_pea, CF); end
    endtask

    task automatic test_simultaneous();
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin spawn(10 + 20 * i, 100, 1'b0); tick(); end
        idle();
        bus.kill_valid = 1'b1; bus.kill_idx = 5'd2; bus.frame_tick = 1'b1; tick(); idle();
        checks++; if (bus.active_mask !== 20'h0000B) begin errors++; $display("FAIL kill_tick_mask: got %h want 0000b", bus.active_mask); end
        draw(74, 100); tick();
        checks++; if (bus.pea_on !== 1'b1 || bus.pea_idx !== 5'd3) begin errors++; $display("FAIL kill_tick_move: got on=%0b idx=%0d want on=1 idx=3", bus.pea_on, bus.pea_idx); end
        draw(50, 100); tick();
        checks++; if (bus.pea_on !== 1'b0) begin errors++; $display("FAIL kill_tick_gone: got on=%0b want 0", bus.pea_on); end
        bus.kill_valid = 1'b1; bus.kill_idx = 5'd0; tick(); idle();
        spawn(200, 100, 1'b0); bus.frame_tick = 1'b1; tick(); idle();
        checks++; if (bus.active_mask !== 20'h0000B) begin errors++; $display("FAIL spawn_tick_mask: got %h want 0000b", bus.active_mask); end
        draw(200, 100); tick();
        checks++; if (bus.pea_on !== 1'b1 || bus.pea_idx !== 5'd0) begin errors++; $display("FAIL spawn_tick_unmoved: got on=%0b idx=%0d want on=1 idx=0", bus.pea_on, bus.pea_idx); end
        draw(78, 100); tick();
        checks++; if (bus.pea_on !== 1'b1 || bus.pea_idx !== 5'd3) begin errors++; $display("FAIL spawn_tick_others: got on=%0b idx=%0d want on=1 idx=3", bus.pea_on, bus.pea_idx); end
        spawn(400, 100, 1'b0); bus.kill_valid = 1'b1; bus.kill_idx = 5'd0; tick(); idle();
        checks++; if (bus.active_mask !== 20'h0000E) begin errors++; $display("FAIL spawn_kill_mask: got %h want 0000e", bus.active_mask); end
        draw(400, 100); tick();
        checks++; if (bus.pea_on !== 1'b1 || bus.pea_idx !== 5'd2) begin errors++; $display("FAIL spawn_kill_slot: got on=%0b idx=%0d want on=1 idx=2", bus.pea_on, bus.pea_idx); end
    endtask

    task automatic test_overlap();
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        spawn(10, 10, 1'b0); tick();
        spawn(300, 300, 1'b1); tick();
        spawn(50, 50, 1'b0); tick();
        spawn(303, 303, 1'b0); tick(); idle();
        draw(305, 305); tick();
        checks++; if (bus.pea_on !== 1'b1 || bus.pea_idx !== 5'd1 || bus.RGB_pea !== CF)
            begin errors++; $display("FAIL overlap_low: got on=%0b idx=%0d rgb=%h want on=1 idx=1 rgb=%h", bus.pea_on, bus.pea_idx, bus.RGB_pea, CF); end
        bus.kill_valid = 1'b1; bus.kill_idx = 5'd5; tick();
        checks++; if (bus.active_mask !== 20'h0000F || bus.active_count !== 6'd4)
            begin errors++; $display("FAIL kill_inactive: got mask=%h count=%0d want mask=0000f count=4", bus.active_mask, bus.active_count); end
        bus.kill_idx = 5'd31; tick();
        checks++; if (bus.active_mask !== 20'h0000F) begin errors++; $display("FAIL kill_range: got %h want 0000f", bus.active_mask); end
        bus.kill_idx = 5'd1; tick(); idle(); tick();
        checks++; if (bus.pea_on !== 1'b1 || bus.pea_idx !== 5'd3 || bus.RGB_pea !== CN)
            begin errors++; $display("FAIL overlap_next: got on=%0b idx=%0d rgb=%h want on=1 idx=3 rgb=%h", bus.pea_on, bus.pea_idx, bus.RGB_pea, CN); end
    endtask

    task automatic test_random();
        int s;
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bus.spawn_valid = ($urandom_range(0, 2) == 0);
            bus.spawn_x     = 10'($urandom_range(0, 639));
            bus.spawn_y     = 10'($urandom_range(0, 479));
            bus.spawn_type  = 1'($urandom_range(0, 1));
            bus.kill_valid  = ($urandom_range(0, 3) == 0);
            bus.kill_idx    = 5'($urandom_range(0, 31));
            bus.frame_tick  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) begin
                s = int'($urandom_range(0, NP - 1));
                draw(m_x[s] + int'($urandom_range(0, 9)) - 1, m_y[s] + int'($urandom_range(0, 9)) - 1);
            end else begin
                draw(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end
            tick();
            checks++; if (bus.pea_on !== e_on || bus.pea_idx !== IW'(e_idx) || bus.RGB_pea !== e_rgb)
                begin errors++; $display("FAIL rand_pixel_%0d: got on=%0b idx=%0d rgb=%h want on=%0b idx=%0d rgb=%h", c, bus.pea_on, bus.pea_idx, bus.RGB_pea, e_on, e_idx, e_rgb); end
            checks++; if (bus.active_mask !== m_mask() || bus.active_count !== 6'(m_count()))
                begin errors++; $display("FAIL rand_pool_%0d: got mask=%h count=%0d want mask=%h count=%0d", c, bus.active_mask, bus.active_count, m_mask(), m_count()); end
            checks++; if (bus.spawn_ready !== (m_count() < NP))
                begin errors++; $display("FAIL rand_ready_%0d: got %0b want %0b", c, bus.spawn_ready, m_count() < NP); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 3; i++) begin spawn(100 + 20 * i, 60, 1'b1); tick(); end
        idle(); draw(101, 61);
        rst = 1'b1; spawn(5, 5, 1'b0); bus.frame_tick = 1'b1; bus.kill_valid = 1'b1; tick();
        rst = 1'b0; idle();
        checks++; if (bus.pea_on !== 1'b0 || bus.RGB_pea !== CB || bus.pea_idx !== '0)
            begin errors++; $display("FAIL midreset_pixel: got on=%0b rgb=%h idx=%0d want on=0 rgb=%h idx=0", bus.pea_on, bus.RGB_pea, bus.pea_idx, CB); end
        checks++; if (bus.active_mask !== '0 || bus.active_count !== 6'd0 || bus.spawn_ready !== 1'b1)
            begin errors++; $display("FAIL midreset_pool: got mask=%h count=%0d ready=%0b want mask=0 count=0 ready=1", bus.active_mask, bus.active_count, bus.spawn_ready); end
    endtask

    initial begin
        idle(); draw(0, 0);
        test_reset();
        test_spawn_pixel();
        test_move();
        test_fill();
        test_simultaneous();
        test_overlap();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
